binary_to_bcd_seq: RTL and testbench
====================================

# binary_to_bcd_seq

Sequential binary-to-BCD encoder using shift-and-add-3 (double dabble), one bit per clock. It converts an internal binary index (player, level or selection number) into packed BCD digits for the seven-segment display path. It is the encoder counterpart to the BCD-to-binary decoder. An optional offset maps a 0-based index onto a 1-based displayed number, so binary 0 shows as BCD 1 by default.

## Interface
Parameters:
- BIN_W, default 8: width of the binary input.
- DIGITS, default 3: number of BCD digits produced. Elaboration fails unless 10^DIGITS > (2^BIN_W − 1) + OFFSET.
- OFFSET, default 1: constant added to `bin` before conversion. Range 0..1.

Ports:
- clk, input, 1: single clock. All state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a conversion. Sampled only while busy=0.
- bin, input, BIN_W: value to convert. Sampled in the cycle start is accepted.
- busy, output, 1: high while a conversion is in progress, including the done cycle.
- done, output, 1: one-cycle pulse when bcd holds the new result.
- bcd, output, 4*DIGITS: packed BCD, digit 0 in bits [3:0]. Holds its value between conversions.

## Operation
- FSM states:
  - IDLE: busy=0. On start=1, load shift register = bin + OFFSET (BIN_W+1 bits, no truncation), clear the digit accumulator, set count = BIN_W+1, go to SHIFT.
  - SHIFT: each cycle, first every digit ≥5 gets +3 (4-bit, no carry out), then shift {digits, shreg} left by 1 and decrement count. When count reaches 1 in this cycle (last shift), go to DONE.
  - DONE: bcd <= accumulator, done=1, go to IDLE.
- start while busy=1 is ignored; it is not queued. bin changes while busy have no effect.
- bcd updates only on entry to DONE. Between conversions it holds the last result.
- With OFFSET=0, bin=0 converts to all-zero BCD. No leading-zero blanking is done here; the display driver handles that.

## Timing
- Reset values: state=IDLE, busy=0, done=0, bcd=0, accumulator=0, count=0.
- start accepted at edge N: busy=1 from cycle N+1, SHIFT occupies cycles N+1..N+BIN_W+1.
- done=1 and new bcd appear in cycle N+BIN_W+2. For default parameters that is 10 cycles after start.
- busy falls in cycle N+BIN_W+3. The earliest next start is sampled at that edge, so back-to-back throughput is one result per BIN_W+3 cycles.
- start=1 in the DONE cycle is ignored (busy=1).
- rst mid-conversion: at the next edge, return to IDLE with every output at its reset value. No done pulse is produced for the aborted conversion.
- rst and start in the same cycle: rst wins.

## Structure
- Package bcd_pkg holds:
  - FSM state typedef (IDLE, SHIFT, DONE).
  - BCD_DIGIT_W=4.
  - ADJ_THRESH=5 and ADJ_ADD=3.
  - A function computing the minimum digits, used by the elaboration check.
- Sub-module bcd_digit_adjust: combinational, 4 bits in and out, adds 3 if the input is ≥5. Instantiated DIGITS times by generate.
- Top level contains the FSM, the count register (width clog2(BIN_W+2)), the shift register and the output register.

## Test plan
- Reset, then bin=0, OFFSET=1, start pulse: done at cycle +10, bcd=0x001, busy low one cycle later.
- bin=254: bcd=0x255. Then bin=255: bcd=0x256. Both done pulses are exactly one cycle wide.
- OFFSET=0 instance, bin=99: bcd=0x099. bin=0: bcd=0x000.
- start held high continuously from reset with bin=7: results 0x008 appear every 11 cycles, and starts during busy and the DONE cycle create no extra conversions.
- Conversion of bin=42 followed by bin changed to 200 during SHIFT: result is 0x043 and is held unchanged for 20 idle cycles.
- rst asserted 4 cycles into a conversion: next cycle busy=0, done=0, bcd=0. No done pulse follows. A fresh start then converts correctly.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD encoder.
// Holds the FSM encoding, the double-dabble adjust constants and the digit-count helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int ADJ_THRESH  = 5;
    localparam int ADJ_ADD     = 3;

    // Smallest digit count able to show the largest offset-adjusted input.
    function automatic int minDigits(input int binW, input int offset);
        longint maxVal;
        longint limit;
        int     digits;
        maxVal = (longint'(1) << binW) - 1 + longint'(offset);
        limit  = 10;
        digits = 1;
        while (limit <= maxVal) begin
            digits++;
            limit = limit * 10;
        end
        return digits;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction stage: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= BCD_DIGIT_W'(ADJ_THRESH))
                   ? i_digit + BCD_DIGIT_W'(ADJ_ADD)
                   : i_digit;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD encoder, one shift-and-add-3 step per clock.
// The optional OFFSET turns a 0-based index into the 1-based number shown on the display.
module binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int OFFSET = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

    localparam int SH_W  = BIN_W + 1;
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 2);

    if (OFFSET < 0 || OFFSET > 1) begin : g_badOffset
        $error("binary_to_bcd_seq: OFFSET must be 0 or 1");
    end
    if (DIGITS < minDigits(BIN_W, OFFSET)) begin : g_badDigits
        $error("binary_to_bcd_seq: DIGITS too small for BIN_W and OFFSET");
    end

    state_t                  r_state;
    state_t                  w_nextState;
    logic [SH_W-1:0]         r_shreg;
    logic [BCD_W-1:0]        r_acc;
    logic [BCD_W-1:0]        r_bcd;
    logic [CNT_W-1:0]        r_count;
    logic [BCD_W-1:0]        w_accAdj;
    logic [BCD_W+SH_W-1:0]   w_shifted;
    logic                    w_lastShift;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit(r_acc[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit(w_accAdj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The carry out of the top digit is dropped; the DIGITS check guarantees it is always zero.
    assign w_shifted   = {w_accAdj, r_shreg} << 1;
    assign w_lastShift = (r_state == SHIFT) && (r_count == CNT_W'(1));
    assign bcd         = r_bcd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (w_lastShift) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The result register is loaded on the final shift so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_bcd   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shreg <= {1'b0, bin} + SH_W'(OFFSET);
                        r_acc   <= '0;
                        r_count <= CNT_W'(BIN_W + 1);
                    end
                end
                SHIFT: begin
                    r_acc   <= w_shifted[BCD_W+SH_W-1 -: BCD_W];
                    r_shreg <= w_shifted[SH_W-1:0];
                    r_count <= r_count - CNT_W'(1);
                    if (w_lastShift) begin
                        r_bcd <= w_shifted[BCD_W+SH_W-1 -: BCD_W];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench for binary_to_bcd_seq: an OFFSET=1 and an OFFSET=0 instance share
// clock and reset; expected results come from decimal arithmetic on the accepted input.
module tb_binary_to_bcd_seq;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int LAT    = BIN_W + 1;
    localparam int PERIOD = BIN_W + 3;

    typedef struct {
        logic [BCD_W-1:0] bcd;
        int               doneEdge;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             startIn [2];
    logic [BIN_W-1:0] binIn   [2];
    logic             busyO   [2];
    logic             doneO   [2];
    logic [BCD_W-1:0] bcdO    [2];

    int               checks       = 0;
    int               errors       = 0;
    int               edgeCnt      = 0;
    bit               rstAtEdge    = 1'b0;
    int               lastAccept [2] = '{-100, -100};
    int               freeEdge   [2] = '{0, 0};
    logic [BCD_W-1:0] modelBcd   [2] = '{'0, '0};
    exp_t             expQ [2][$];

    always #5 clk = ~clk;

    binary_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .OFFSET(1)) u_dutOff1 (
        .clk(clk), .rst(rst), .start(startIn[0]), .bin(binIn[0]),
        .busy(busyO[0]), .done(doneO[0]), .bcd(bcdO[0])
    );

    binary_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .OFFSET(0)) u_dutOff0 (
        .clk(clk), .rst(rst), .start(startIn[1]), .bin(binIn[1]),
        .busy(busyO[1]), .done(doneO[1]), .bcd(bcdO[1])
    );

    function automatic logic [BCD_W-1:0] refBcd(input int value);
        logic [BCD_W-1:0] r;
        int               v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int offsetOf(input int u);
        return (u == 0) ? 1 : 0;
    endfunction

    // One clock: at the rising edge decide, from the inputs just sampled, whether each
    // unit accepts a conversion, and queue its expected result and completion edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        edgeCnt++;
        rstAtEdge = rst;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                expQ[u].delete();
                lastAccept[u] = -100;
                freeEdge[u]   = edgeCnt + 1;
            end else if (startIn[u] && edgeCnt >= freeEdge[u]) begin
                e.bcd      = refBcd(int'(binIn[u]) + offsetOf(u));
                e.doneEdge = edgeCnt + LAT;
                expQ[u].push_back(e);
                lastAccept[u] = edgeCnt;
                freeEdge[u]   = edgeCnt + PERIOD;
            end
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int u, input int value, input int idleTicks);
        startIn[u] = 1'b1;
        binIn[u]   = BIN_W'(value);
        tick();
        startIn[u] = 1'b0;
        repeat (idleTicks) tick();
    endtask

    task automatic checkOutput();
        exp_t e;
        logic expBusy;
        for (int u = 0; u < 2; u++) begin
            if (rstAtEdge) modelBcd[u] = '0;
            if (doneO[u]) begin
                checks++;
                if (expQ[u].size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpectedDone unit %0d edge %0d: got done=1, want done=0", u, edgeCnt);
                end else begin
                    e = expQ[u].pop_front();
                    checks++;
                    if (bcdO[u] !== e.bcd) begin
                        errors++;
                        $display("[TB] FAIL resultBcd unit %0d edge %0d: got %03h, want %03h", u, edgeCnt, bcdO[u], e.bcd);
                    end
                    checks++;
                    if (edgeCnt != e.doneEdge) begin
                        errors++;
                        $display("[TB] FAIL doneTiming unit %0d: got done at edge %0d, want edge %0d", u, edgeCnt, e.doneEdge);
                    end
                    modelBcd[u] = e.bcd;
                end
            end else if (expQ[u].size() > 0 && expQ[u][0].doneEdge <= edgeCnt) begin
                checks++;
                errors++;
                $display("[TB] FAIL missingDone unit %0d edge %0d: got done=0, want done=1", u, edgeCnt);
                modelBcd[u] = expQ[u][0].bcd;
                void'(expQ[u].pop_front());
            end
            expBusy = (edgeCnt >= lastAccept[u]) && (edgeCnt <= lastAccept[u] + LAT);
            checks++;
            if (busyO[u] !== expBusy) begin
                errors++;
                $display("[TB] FAIL busy unit %0d edge %0d: got %b, want %b", u, edgeCnt, busyO[u], expBusy);
            end
            checks++;
            if (bcdO[u] !== modelBcd[u]) begin
                errors++;
                $display("[TB] FAIL bcdValue unit %0d edge %0d: got %03h, want %03h", u, edgeCnt, bcdO[u], modelBcd[u]);
            end
        end
    endtask

    always @(negedge clk) checkOutput();

    initial begin
        rst        = 1'b1;
        startIn[0] = 1'b0;
        startIn[1] = 1'b0;
        binIn[0]   = '0;
        binIn[1]   = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Directed values, including the top of the input range on the offset unit.
        applyStimulus(0, 0, 12);
        applyStimulus(0, 254, 12);
        applyStimulus(0, 255, 12);
        applyStimulus(1, 99, 12);
        applyStimulus(1, 0, 12);

        // Start held high through and after reset: one result per PERIOD, no extras.
        startIn[0] = 1'b1;
        binIn[0]   = 8'd7;
        rst        = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (45) tick();
        startIn[0] = 1'b0;
        repeat (12) tick();

        // Input changes mid-conversion must not disturb the result or the held value.
        startIn[0] = 1'b1;
        binIn[0]   = 8'd42;
        tick();
        startIn[0] = 1'b0;
        repeat (3) tick();
        binIn[0] = 8'd200;
        repeat (30) tick();

        // Reset a few cycles into a conversion on both units, then convert again.
        startIn[0] = 1'b1;
        binIn[0]   = 8'd123;
        startIn[1] = 1'b1;
        binIn[1]   = 8'd50;
        tick();
        startIn[0] = 1'b0;
        startIn[1] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (15) tick();
        applyStimulus(0, 77, 12);
        applyStimulus(1, 201, 12);

        // Random start pulses, input values and occasional resets.
        repeat (600) begin
            for (int u = 0; u < 2; u++) begin
                startIn[u] = ($urandom_range(0, 3) == 0);
                binIn[u]   = BIN_W'($urandom_range(0, 255));
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst        = 1'b0;
        startIn[0] = 1'b0;
        startIn[1] = 1'b0;
        repeat (15) tick();

        for (int u = 0; u < 2; u++) begin
            checks++;
            if (expQ[u].size() != 0) begin
                errors++;
                $display("[TB] FAIL pendingResults unit %0d: got %0d outstanding, want 0", u, expQ[u].size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
